// File: rtl/iram_loader_pkg.sv
// Shared CPU package: loader frame marker, loader FSM encoding and the
// instruction memory geometry used by the loader and its storage.
package iram_loader_pkg;

    // Frame start marker on the loader byte stream.
    localparam logic [7:0] IRAM_SYNC_BYTE = 8'hA5;

    // Instruction memory geometry: 128 words of 16 bits, 7-bit word index.
    localparam int IRAM_DEPTH = 128;
    localparam int IRAM_WIDTH = 16;
    localparam int IRAM_AW    = 7;

    // Loader frame parser states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        COUNT   = 3'd2,
        DATA_HI = 3'd3,
        DATA_LO = 3'd4,
        CHECK   = 3'd5
    } state_t;

endpackage

// File: rtl/iram_loader_store.sv
// Instruction word storage: one synchronous write port, one combinational
// read port, whole array cleared synchronously while RESET is high.
module iram_store
    import iram_loader_pkg::*;
#(
    parameter int DEPTH = IRAM_DEPTH
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  we,
    input  logic [IRAM_AW-1:0]    waddr,
    input  logic [IRAM_WIDTH-1:0] wdata,
    input  logic [IRAM_AW-1:0]    raddr,
    output logic [IRAM_WIDTH-1:0] rdata
);

    logic [IRAM_WIDTH-1:0] mem [0:DEPTH-1];

    // Clear every word on reset, otherwise take the single write port.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Fetch path is purely combinational so a written word shows up on the
    // next cycle without an extra read latency.
    assign rdata = mem[raddr];

endmodule

// File: rtl/iram_loader.sv
// Loader for the CPU instruction RAM. Parses framed byte streams
// (SYNC, START, COUNT, data pairs high byte first, XOR checksum) and writes
// 16-bit words into the store while holding the CPU off the fetch port.
//
// Handshake: a byte is transferred on a rising CLK edge where
// IN_VALID && IN_READY. IN_READY is low only while RESET is high, so the
// loader never applies backpressure; cycles with IN_VALID low change nothing.
module iram_loader
    import iram_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = IRAM_SYNC_BYTE,
    parameter int         WORDS     = IRAM_DEPTH
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [7:0]            IN_DATA,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [7:0]            ADDR,
    output logic [IRAM_WIDTH-1:0] Q,
    output logic                  CPU_HOLD,
    output logic                  DONE,
    output logic                  ERR,
    output state_t                DBG_STATE
);

    state_t             state_q, state_d;
    logic [IRAM_AW-1:0] ptr_q, ptr_d;
    logic [7:0]         cnt_q, cnt_d;   // words left, 1..128
    logic [7:0]         hi_q, hi_d;
    logic [7:0]         chk_q, chk_d;
    logic               hold_q, hold_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               mem_we;
    logic               accept;
    logic               unused_addr_lsb;

    // Bytes are rejected only during reset.
    assign IN_READY = ~RESET;
    assign accept   = IN_VALID & IN_READY;

    // Byte address bit 0 selects nothing: fetch is word-granular.
    assign unused_addr_lsb = ADDR[0];

    iram_store #(
        .DEPTH (WORDS)
    ) u_store (
        .CLK   (CLK),
        .RESET (RESET),
        .we    (mem_we),
        .waddr (ptr_q),
        .wdata ({hi_q, IN_DATA}),
        .raddr (ADDR[7:1]),
        .rdata (Q)
    );

    // State register and datapath registers; reset abandons any frame.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            chk_q   <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            chk_q   <= chk_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Frame parser: next state, datapath updates and result pulses.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        chk_d   = chk_q;
        mem_we  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    // Anything but the marker is line noise between frames.
                    if (IN_DATA == SYNC_BYTE) begin
                        state_d = START;
                        chk_d   = '0;
                    end
                end
                START: begin
                    ptr_d   = IN_DATA[IRAM_AW-1:0];
                    state_d = COUNT;
                end
                COUNT: begin
                    // A zero count means a full-memory load.
                    cnt_d   = (IN_DATA == 8'd0) ? 8'd128 : IN_DATA;
                    state_d = DATA_HI;
                end
                DATA_HI: begin
                    hi_d    = IN_DATA;
                    chk_d   = chk_q ^ IN_DATA;
                    state_d = DATA_LO;
                end
                DATA_LO: begin
                    mem_we  = 1'b1;
                    chk_d   = chk_q ^ IN_DATA;
                    ptr_d   = ptr_q + 1'b1;   // wraps 127 -> 0
                    cnt_d   = cnt_q - 8'd1;
                    state_d = (cnt_q == 8'd1) ? CHECK : DATA_HI;
                end
                CHECK: begin
                    // Written words stay in place even on a bad checksum.
                    if (IN_DATA == chk_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        hold_d = (state_d != IDLE);
    end

    assign CPU_HOLD  = hold_q;
    assign DONE      = done_q;
    assign ERR       = err_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_iram_loader.sv
// Directed bench for iram_loader: frame loads, address wrap, bad checksum,
// leading junk, reset mid-frame and idle gaps between bytes.
module tb_iram_loader;
    import iram_loader_pkg::*;

    logic        CLK;
    logic        RESET;
    logic [7:0]  IN_DATA;
    logic        IN_VALID;
    logic        IN_READY;
    logic [7:0]  ADDR;
    logic [15:0] Q;
    logic        CPU_HOLD;
    logic        DONE;
    logic        ERR;
    state_t      DBG_STATE;

    int n_cmp;
    int n_bad;
    int done_cnt;
    int err_cnt;
    int both_cnt;

    iram_loader dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IN_DATA   (IN_DATA),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .ADDR      (ADDR),
        .Q         (Q),
        .CPU_HOLD  (CPU_HOLD),
        .DONE      (DONE),
        .ERR       (ERR),
        .DBG_STATE (DBG_STATE)
    );

    // Clock: 10 ns period.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge CLK) begin
        if (DONE) done_cnt++;
        if (ERR) err_cnt++;
        if (DONE && ERR) both_cnt++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one byte for exactly one accepting edge.
    task automatic send_byte(input logic [7:0] b);
        IN_DATA  = b;
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        IN_DATA  = 8'h00;
    endtask

    task automatic rd(input logic [7:0] a, output logic [15:0] v);
        ADDR = a;
        #1;
        v = Q;
    endtask

    // Hold RESET for n cycles with the sync byte offered the whole time.
    task automatic do_reset(input int n);
        RESET    = 1'b1;
        IN_VALID = 1'b1;
        IN_DATA  = 8'hA5;
        repeat (n) tick();
        RESET    = 1'b0;
        IN_VALID = 1'b0;
        IN_DATA  = 8'h00;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        RESET    = 1'b1;
        IN_VALID = 1'b1;
        IN_DATA  = 8'hA5;
        tick();
        tick();
        n_cmp++;
        if (IN_READY !== 1'b0) begin
            n_bad++; $display("FAIL reset_in_ready: got %b want 0", IN_READY);
        end
        n_cmp++;
        if (CPU_HOLD !== 1'b0) begin
            n_bad++; $display("FAIL reset_cpu_hold: got %b want 0", CPU_HOLD);
        end
        n_cmp++;
        if ({DONE, ERR} !== 2'b00) begin
            n_bad++; $display("FAIL reset_pulses: got %b want 00", {DONE, ERR});
        end
        RESET    = 1'b0;
        IN_VALID = 1'b0;
        #1;
        n_cmp++;
        if (IN_READY !== 1'b1) begin
            n_bad++; $display("FAIL ready_after_reset: got %b want 1", IN_READY);
        end
        n_cmp++;
        if (DBG_STATE !== IDLE) begin
            n_bad++; $display("FAIL reset_state: got %0d want %0d", DBG_STATE, IDLE);
        end
        rd(8'h00, v);
        n_cmp++;
        if (v !== 16'h0000) begin
            n_bad++; $display("FAIL reset_mem0: got %h want 0000", v);
        end
    endtask

    task automatic test_basic(input int max_gap);
        logic [15:0] v;
        logic [7:0]  fr [0:6];
        int d0, e0;
        fr = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        d0 = done_cnt;
        e0 = err_cnt;
        ADDR = 8'h00;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) repeat ($urandom_range(0, max_gap)) tick();
            send_byte(fr[i]);
            if (i == 0) begin
                n_cmp++;
                if (CPU_HOLD !== 1'b1) begin
                    n_bad++; $display("FAIL basic_hold_on_sync: got %b want 1", CPU_HOLD);
                end
            end
            if (i == 4) begin
                rd(8'h00, v);
                n_cmp++;
                if (v !== 16'h1234) begin
                    n_bad++; $display("FAIL basic_write_visible: got %h want 1234", v);
                end
            end
        end
        if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
        send_byte(8'h40);
        n_cmp++;
        if ({DONE, ERR} !== 2'b10) begin
            n_bad++; $display("FAIL basic_done_err: got %b want 10", {DONE, ERR});
        end
        n_cmp++;
        if (CPU_HOLD !== 1'b0) begin
            n_bad++; $display("FAIL basic_hold_release: got %b want 0", CPU_HOLD);
        end
        tick();
        n_cmp++;
        if (DONE !== 1'b0) begin
            n_bad++; $display("FAIL basic_done_width: got %b want 0", DONE);
        end
        n_cmp++;
        if ((done_cnt - d0) !== 1 || (err_cnt - e0) !== 0) begin
            n_bad++; $display("FAIL basic_pulse_count: got done %0d err %0d want 1 0", done_cnt - d0, err_cnt - e0);
        end
        rd(8'h00, v);
        n_cmp++;
        if (v !== 16'h1234) begin
            n_bad++; $display("FAIL basic_mem0: got %h want 1234", v);
        end
        rd(8'h01, v);
        n_cmp++;
        if (v !== 16'h1234) begin
            n_bad++; $display("FAIL basic_addr_lsb: got %h want 1234", v);
        end
        rd(8'h02, v);
        n_cmp++;
        if (v !== 16'hABCD) begin
            n_bad++; $display("FAIL basic_mem1: got %h want ABCD", v);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] v;
        logic [7:0]  fr [0:7];
        int d0;
        fr = '{8'hA5, 8'h7F, 8'h02, 8'h11, 8'h11, 8'h22, 8'h22, 8'h00};
        d0 = done_cnt;
        for (int i = 0; i < 8; i++) send_byte(fr[i]);
        tick();
        n_cmp++;
        if ((done_cnt - d0) !== 1) begin
            n_bad++; $display("FAIL wrap_done: got %0d want 1", done_cnt - d0);
        end
        rd(8'hFE, v);
        n_cmp++;
        if (v !== 16'h1111) begin
            n_bad++; $display("FAIL wrap_mem127: got %h want 1111", v);
        end
        rd(8'h00, v);
        n_cmp++;
        if (v !== 16'h2222) begin
            n_bad++; $display("FAIL wrap_mem0: got %h want 2222", v);
        end
    endtask

    task automatic test_bad_checksum();
        logic [15:0] v;
        logic [7:0]  fr [0:4];
        int d0, e0;
        fr = '{8'hA5, 8'h05, 8'h01, 8'hDE, 8'hAD};
        d0 = done_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 5; i++) send_byte(fr[i]);
        send_byte(8'h00);   // correct would be DE^AD = 73
        n_cmp++;
        if ({DONE, ERR} !== 2'b01) begin
            n_bad++; $display("FAIL bad_done_err: got %b want 01", {DONE, ERR});
        end
        tick();
        n_cmp++;
        if (CPU_HOLD !== 1'b0 || DBG_STATE !== IDLE) begin
            n_bad++; $display("FAIL bad_idle_after: got hold %b state %0d want 0 %0d", CPU_HOLD, DBG_STATE, IDLE);
        end
        n_cmp++;
        if ((err_cnt - e0) !== 1 || (done_cnt - d0) !== 0) begin
            n_bad++; $display("FAIL bad_pulse_count: got err %0d done %0d want 1 0", err_cnt - e0, done_cnt - d0);
        end
        rd(8'h0A, v);
        n_cmp++;
        if (v !== 16'hDEAD) begin
            n_bad++; $display("FAIL bad_mem5_kept: got %h want DEAD", v);
        end
    endtask

    task automatic test_leading_junk();
        logic [15:0] v;
        logic [7:0]  fr [0:7];
        int d0;
        do_reset(2);
        fr = '{8'h00, 8'hFF, 8'hA5, 8'h03, 8'h01, 8'h00, 8'h07, 8'h07};
        d0 = done_cnt;
        for (int i = 0; i < 8; i++) begin
            send_byte(fr[i]);
            if (i == 1) begin
                n_cmp++;
                if (CPU_HOLD !== 1'b0 || DBG_STATE !== IDLE) begin
                    n_bad++; $display("FAIL junk_ignored: got hold %b state %0d want 0 %0d", CPU_HOLD, DBG_STATE, IDLE);
                end
            end
        end
        tick();
        n_cmp++;
        if ((done_cnt - d0) !== 1) begin
            n_bad++; $display("FAIL junk_done: got %0d want 1", done_cnt - d0);
        end
        for (int w = 0; w < 128; w++) begin
            rd(8'(w * 2), v);
            n_cmp++;
            if (v !== ((w == 3) ? 16'h0007 : 16'h0000)) begin
                n_bad++; $display("FAIL junk_mem[%0d]: got %h want %h", w, v, (w == 3) ? 16'h0007 : 16'h0000);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] v;
        logic [7:0]  fr [0:5];
        int bad;
        fr = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 6; i++) send_byte(fr[i]);
        rd(8'h20, v);
        n_cmp++;
        if (v !== 16'h1122) begin
            n_bad++; $display("FAIL mid_word1_written: got %h want 1122", v);
        end
        do_reset(2);
        n_cmp++;
        if (CPU_HOLD !== 1'b0 || DBG_STATE !== IDLE) begin
            n_bad++; $display("FAIL mid_abort: got hold %b state %0d want 0 %0d", CPU_HOLD, DBG_STATE, IDLE);
        end
        bad = 0;
        for (int w = 0; w < 128; w++) begin
            rd(8'(w * 2), v);
            if (v !== 16'h0000) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_bad++; $display("FAIL mid_mem_cleared: got %0d nonzero words want 0", bad);
        end
        test_basic(0);
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        done_cnt = 0;
        err_cnt  = 0;
        both_cnt = 0;
        RESET    = 1'b1;
        IN_VALID = 1'b0;
        IN_DATA  = 8'h00;
        ADDR     = 8'h00;
        test_reset();
        test_basic(0);
        test_wrap();
        test_bad_checksum();
        test_leading_junk();
        test_reset_mid_frame();
        do_reset(2);
        test_basic(5);
        n_cmp++;
        if (both_cnt !== 0) begin
            n_bad++; $display("FAIL done_err_exclusive: got %0d overlaps want 0", both_cnt);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/iram_loader.md
IRAM_LOADER -- requirements
Module: iram_loader

Interface
REQ-001 SHALL provide parameter SYNC_BYTE, default 8'hA5, the frame start marker.
REQ-002 SHALL provide parameter WORDS, default 128, the number of 16-bit memory entries (word index width 7).
REQ-003 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET, input, 1, synchronous active-high reset.
REQ-005 SHALL have port IN_DATA, input, 8, loader byte stream data.
REQ-006 SHALL have port IN_VALID, input, 1, meaning IN_DATA holds a byte.
REQ-007 SHALL have port IN_READY, output, 1, meaning a byte is accepted when IN_VALID & IN_READY.
REQ-008 SHALL have port ADDR, input, 8, CPU fetch byte address; word index = ADDR[7:1].
REQ-009 SHALL have port Q, output, 16, instruction word at mem[ADDR[7:1]].
REQ-010 SHALL have port CPU_HOLD, output, 1, meaning the CPU must stall fetch while a load is in progress.
REQ-011 SHALL have port DONE, output, 1, a one-cycle pulse on a good checksum.
REQ-012 SHALL have port ERR, output, 1, a one-cycle pulse on a bad checksum.

Function
REQ-013 SHALL drive Q combinationally from mem[ADDR[7:1]]; ADDR[0] is ignored.
REQ-014 SHALL parse each frame as SYNC_BYTE, START (word index, bit 7 ignored), COUNT (0 means 128), then 2*COUNT data bytes high byte first, then CHK.
REQ-015 SHALL use FSM states IDLE, START, COUNT, DATA_HI, DATA_LO, CHECK.
REQ-016 SHALL, in IDLE, discard any accepted byte not equal to SYNC_BYTE; SYNC_BYTE moves to START.
REQ-017 SHALL take transitions START->COUNT->DATA_HI->DATA_LO, each on an accepted byte.
REQ-018 SHALL, in DATA_LO, write {hi,lo} to mem[ptr] on the accepting edge, increment ptr modulo 128 (127 wraps to 0) and decrement the remaining count.
REQ-019 SHALL go to CHECK when the remaining count reaches 0 after a write, otherwise return to DATA_HI.
REQ-020 SHALL keep the checksum as the XOR of all data bytes only, cleared on entering START.
REQ-021 SHALL, in CHECK, pulse DONE when the accepted byte equals the checksum and pulse ERR otherwise, in the cycle after acceptance; in both cases the FSM returns to IDLE.
REQ-022 SHALL NOT roll back written words on ERR.
REQ-023 SHALL make a written word visible on Q in the cycle after the write edge.
REQ-024 SHALL hold IN_READY at 1 in every state when RESET is low; there is no backpressure otherwise.
REQ-025 SHALL assert CPU_HOLD from the edge that accepts SYNC_BYTE until the FSM returns to IDLE; CPU_HOLD is registered.
REQ-026 SHALL make idle cycles (IN_VALID=0) mid-frame change no state; there is no timeout.
REQ-027 SHALL make DONE and ERR mutually exclusive.

Reset
REQ-028 SHALL, while RESET=1, set the FSM to IDLE, CPU_HOLD=0, DONE=0, ERR=0, IN_READY=0, ptr=0, count=0 and checksum=0.
REQ-029 SHALL clear all 128 memory words to 16'h0000 on RESET.
REQ-030 SHALL abort a frame interrupted by RESET mid-frame, leaving no partial effect after reset.
REQ-031 SHALL reject any byte presented during RESET.

Structure
REQ-032 SHALL place SYNC_BYTE, the FSM state encodings and the memory depth/width constants in the shared CPU package.
REQ-033 SHALL place storage in sub-module iram_store: 128x16, one synchronous write port, one combinational read port, synchronous clear on RESET.

Verification
REQ-034 SHALL test frame A5,00,02,12,34,AB,CD,(12^34^AB^CD=40): required result mem[0]=1234, mem[1]=ABCD, DONE for 1 cycle, Q=ABCD at ADDR=8'h02.
REQ-035 SHALL test wrap: A5,7F,02,11,11,22,22,00 -> mem[127]=1111, mem[0]=2222, DONE.
REQ-036 SHALL test bad checksum: A5,05,01,DE,AD,00 -> mem[5]=DEAD, ERR pulse, no DONE, CPU_HOLD low afterwards.
REQ-037 SHALL test leading junk: 00,FF,A5,03,01,00,07,07 -> only mem[3]=0007 is written, DONE.
REQ-038 SHALL test RESET asserted after the DATA_HI byte of word 2 of a 3-word frame -> all mem=0, CPU_HOLD=0, and a following valid frame loads correctly.
REQ-039 SHALL test IN_VALID gaps of 0-5 random cycles between bytes of the REQ-034 frame -> identical result.
